// File: rtl/conv_job_scheduler_if.sv
// Requester/engine handshake bundle for the convolution job scheduler.
// The slave modport is the scheduler's view; master is the opposite side.
interface conv_job_scheduler_if #(
    parameter int LEN_W = 6
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic             src_sel;
    logic             src_valid;
    logic             src_ready;
    logic             eng_weight_valid;
    logic             eng_in_valid;
    logic             eng_out_valid;
    logic [12:0]      eng_ofm;
    logic             res_valid;
    logic             res_id;
    logic [12:0]      res_data;
    logic             res_last;
    logic             done;
    logic             err;
    logic             busy;

    modport master (
        output req, len0, len1, src_valid, eng_out_valid, eng_ofm,
        input  gnt, src_sel, src_ready, eng_weight_valid, eng_in_valid,
        input  res_valid, res_id, res_data, res_last, done, err, busy
    );

    modport slave (
        input  req, len0, len1, src_valid, eng_out_valid, eng_ofm,
        output gnt, src_sel, src_ready, eng_weight_valid, eng_in_valid,
        output res_valid, res_id, res_data, res_last, done, err, busy
    );
endinterface

// File: rtl/conv_job_scheduler.sv
// Round-robin job controller for the 2x4x4 conv MAC engine: one weight load,
// then len IFM vectors per job, results tagged with requester ID, drain timeout.
module conv_job_scheduler #(
    parameter int TIMEOUT = 15,
    parameter int LEN_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv_job_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WGT, FEED, DRAIN, DONE} state_t;

    localparam int              TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [LEN_W-1:0] job_len_q, job_len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] recv_q, recv_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             src_sel_q, src_sel_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic [12:0]      res_data_q, res_data_d;
    logic             res_last_q, res_last_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             src_ready_c, eng_weight_valid_c, eng_in_valid_c;
    logic             win;
    logic [LEN_W-1:0] win_len, issued_inc, recv_inc;
    logic [TMO_W-1:0] tmo_inc;

    always_comb begin
        state_d            = state_q;
        rr_d               = rr_q;
        job_len_d          = job_len_q;
        issued_d           = issued_q;
        recv_d             = recv_q;
        tmo_d              = tmo_q;
        gnt_d              = gnt_q;
        src_sel_d          = src_sel_q;
        res_valid_d        = 1'b0;
        res_id_d           = res_id_q;
        res_data_d         = res_data_q;
        res_last_d         = 1'b0;
        err_d              = 1'b0;
        src_ready_c        = 1'b0;
        eng_weight_valid_c = 1'b0;
        eng_in_valid_c     = 1'b0;

        issued_inc = issued_q + 1'b1;
        recv_inc   = recv_q + 1'b1;
        tmo_inc    = (tmo_q == TMO_LIM) ? tmo_q : tmo_q + 1'b1;
        // On a tie the requester that was not served last wins.
        win        = (bus.req == 2'b11) ? ~rr_q : bus.req[1];
        win_len    = win ? bus.len1 : bus.len0;

        // Results only belong to a job while it is feeding or draining.
        if ((state_q == FEED || state_q == DRAIN) && bus.eng_out_valid) begin
            recv_d      = recv_inc;
            tmo_d       = '0;
            res_valid_d = 1'b1;
            res_data_d  = bus.eng_ofm;
            res_id_d    = src_sel_q;
            res_last_d  = (recv_inc == job_len_q);
        end

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d   = WGT;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    src_sel_d = win;
                    job_len_d = (win_len == '0) ? LEN_W'(1) : win_len;
                    issued_d  = '0;
                    recv_d    = '0;
                    tmo_d     = '0;
                end
            end
            WGT: begin
                src_ready_c        = 1'b1;
                eng_weight_valid_c = bus.src_valid;
                if (bus.src_valid) state_d = FEED;
            end
            FEED: begin
                src_ready_c    = (issued_q < job_len_q);
                eng_in_valid_c = bus.src_valid & src_ready_c;
                if (eng_in_valid_c) begin
                    issued_d = issued_inc;
                    if (issued_inc == job_len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A result arriving on the would-be timeout cycle keeps the job alive.
                if (recv_q == job_len_q) begin
                    state_d = DONE;
                end else if (!bus.eng_out_valid) begin
                    if (tmo_inc == TMO_LIM) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                rr_d    = src_sel_q;
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b1;
            job_len_q   <= '0;
            issued_q    <= '0;
            recv_q      <= '0;
            tmo_q       <= '0;
            gnt_q       <= '0;
            src_sel_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            job_len_q   <= job_len_d;
            issued_q    <= issued_d;
            recv_q      <= recv_d;
            tmo_q       <= tmo_d;
            gnt_q       <= gnt_d;
            src_sel_q   <= src_sel_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.src_ready        = src_ready_c;
    assign bus.eng_weight_valid = eng_weight_valid_c;
    assign bus.eng_in_valid     = eng_in_valid_c;
    assign bus.gnt              = gnt_q;
    assign bus.src_sel          = src_sel_q;
    assign bus.res_valid        = res_valid_q;
    assign bus.res_id           = res_id_q;
    assign bus.res_data         = res_data_q;
    assign bus.res_last         = res_last_q;
    assign bus.done             = done_q;
    assign bus.err              = err_q;
    assign bus.busy             = busy_q;
endmodule

// File: doc/conv_job_scheduler.md
# conv_job_scheduler

Job controller for the 2×4×4 convolution MAC engine. It arbitrates between two requesters with round-robin and steers the granted requester onto the engine's shared IFM/weight bus. For each job it sequences one weight load and then `len` IFM vectors, and returns each engine result tagged with the requester ID. A drain timeout reports a job whose results never arrive.

## Interface
Parameters:
- `TIMEOUT`, default 15: DRAIN-state cycles with no `eng_out_valid` before the job is aborted with error.
- `LEN_W`, default 6: width of the job length fields.

Ports:
- `clk`  in  1: the single clock for the block.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  2: job request, bit i for requester i. Level signal.
- `len0`, `len1`  in  LEN_W: IFM vector count for each requester's job. Sampled at grant. 0 is treated as 1.
- `gnt`  out  2: one-hot grant. Held for the whole job.
- `src_sel`  out  1: ID of the granted requester. Drives the external bus mux.
- `src_valid`  in  1: the muxed requester presents a beat (weights or IFM).
- `src_ready`  out  1: the scheduler accepts the beat this cycle.
- `eng_weight_valid`  out  1: engine weight-load strobe.
- `eng_in_valid`  out  1: engine IFM strobe.
- `eng_out_valid`  in  1: engine result strobe, one per accepted IFM vector.
- `eng_ofm`  in  13: engine result.
- `res_valid`  out  1: result valid.
- `res_id`  out  1: requester ID for the result.
- `res_data`  out  13: result value.
- `res_last`  out  1: marks the final result of the job.
- `done`  out  1: one-cycle job completion pulse.
- `err`  out  1: qualifies `done` when the job aborted on timeout.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, WGT, FEED, DRAIN, DONE. Reset state is IDLE.
- IDLE:
  - If any `req` bit is set, grant one requester and go to WGT.
  - If both bits are set, the grant goes to the requester not served last. The round-robin pointer resets so that requester 0 wins the first tie.
  - Capture `len` of the winner into `job_len` (0 becomes 1). Clear `issued`, `recv` and the timeout counter.
- WGT:
  - `src_ready=1` and `eng_weight_valid=src_valid`.
  - On `src_valid`, go to FEED.
- FEED:
  - `src_ready = (issued < job_len)` and `eng_in_valid = src_valid & src_ready`.
  - `issued` increments on each accepted beat.
  - When the accepted beat makes `issued == job_len`, go to DRAIN.
- DRAIN:
  - `src_ready=0`.
  - Exit to DONE when `recv == job_len`.
  - Also exit to DONE, with `err`, when the timeout counter reaches TIMEOUT.
- DONE:
  - One cycle. `done=1` and `err` is set as determined.
  - Drop `gnt`, set the round-robin pointer to the served ID, and return to IDLE.
- Results:
  - In FEED or DRAIN, each `eng_out_valid` increments `recv`.
  - The next cycle it produces `res_valid=1`, `res_data=eng_ofm` and `res_id=src_sel`.
  - `res_last=1` when the post-increment `recv == job_len`.
  - `eng_out_valid` in IDLE, WGT or DONE is dropped with no output.
- Timeout counter: counts DRAIN cycles without `eng_out_valid` and clears on every `eng_out_valid`.
- Requester behaviour:
  - A requester that drops `req` mid-job does not abort the job.
  - A requester must hold `req` low after `done` if it has no further job. Otherwise it is re-arbitrated in the next IDLE cycle.
- Width rules: `issued`, `recv` and `job_len` are LEN_W bits. The timeout counter is clog2(TIMEOUT+1) bits and saturates.

## Timing
- Reset values: all outputs are 0, state is IDLE, the round-robin pointer is 1, and all counters are 0.
- `src_ready`, `eng_weight_valid` and `eng_in_valid` are combinational from state, counters and `src_valid`. All other outputs are registered.
- Grant timing: `req` seen in IDLE at cycle t gives `gnt`, `src_sel`, `busy` and state WGT at t+1.
- Minimum job duration is 1 (IDLE) + 1 (WGT) + len (FEED) + engine latency (DRAIN) + 1 (DONE) cycles.
- `res_valid` follows `eng_out_valid` by exactly 1 cycle.
- `done` is asserted in the same cycle as, or after, the `res_last` beat. The earliest new grant is the cycle after `done`.
- Simultaneous events:
  - `eng_out_valid` on the cycle the timeout counter would hit TIMEOUT: the result is counted, the counter clears, and there is no timeout.
  - `eng_out_valid` on the cycle of the FEED→DRAIN transition is counted.
- Reset mid-job: immediate return to IDLE, all outputs go to 0, and no `done` is produced.

## Test plan
- **Single job.** `req=01`, `len0=3`, `src_valid` held high, engine latency 3.
  - `gnt=01` 1 cycle after `req`.
  - 1 `eng_weight_valid` pulse, then 3 consecutive `eng_in_valid` pulses.
  - 3 `res_valid` beats with `res_id=0`, `res_last` on the 3rd.
  - `done=1`, `err=0`.
- **Round-robin.** `req=11` held, `len0=len1=2`.
  - Jobs are granted in order 0, 1, 0, 1.
  - `res_id` matches each job's requester.
- **Source stalls.** `len1=4`; `src_valid` toggles 1,0,0,1,1,0,1.
  - `eng_in_valid` appears only on cycles with `src_valid=1`, exactly 4 times.
  - `src_ready` drops after the 4th accepted beat.
- **Timeout.** `len0=2`; engine returns only 1 result.
  - `done=1`, `err=1` after 15 quiet DRAIN cycles.
  - `gnt` clears and the next request is served.
- **Edge cases.**
  - `len0=0` runs as a 1-vector job.
  - A spurious `eng_out_valid` in IDLE produces no `res_valid`.
  - `rst_n` pulsed low mid-FEED: all outputs 0 within the same cycle, and `req=01` afterwards restarts cleanly.
